fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle RISC-V core. It sits directly upstream of `control_unit`. It owns the program counter and issues one instruction-memory request at a time over a valid/ready handshake. It buffers the returned word in an output register that presents `if_instr`/`if_pc` to decode. Branch, JAL and JALR redirects from execute flush the buffer and discard any in-flight response.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time
// and buffers the returned word for decode.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_req_valid/ready/addr  fetch request handshake, addr = pc
//   imem_rsp_valid/data        one-cycle response pulse with the word
//   redirect_valid/target      taken branch / JAL / JALR from execute
//   if_valid/ready/instr/pc    output buffer towards decode
//   fetch_fault                sticky misaligned-redirect flag
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic [31:0] instr_nx;
    logic [31:0] ipc_nx;
    logic        valid_nx;
    logic        fault_nx;
    logic        buf_free;
    logic        req_fire;
    logic        consume;
    logic        redirect;
    logic        misaligned;

    assign buf_free       = !if_valid || if_ready;
    assign imem_req_valid = (state == S_REQ) && buf_free;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign consume        = if_valid && if_ready;
    assign redirect       = redirect_valid && (state != S_HALT);
    assign misaligned     = redirect_target[1:0] != 2'b00;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = if_instr;
        ipc_nx   = if_pc;
        valid_nx = if_valid;
        fault_nx = fetch_fault;

        if (consume) begin
            valid_nx = 1'b0;
        end

        unique case (state)
            S_IDLE: state_nx = S_REQ;
            S_REQ: begin
                if (req_fire) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_nx = imem_rsp_data;
                    ipc_nx   = pc;
                    valid_nx = 1'b1;
                    pc_nx    = pc + 32'd4;
                    state_nx = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_nx = S_REQ;
                end
            end
            S_HALT: begin
            end
            default: state_nx = S_HALT;
        endcase

        // Redirect overrides any capture decided above.
        if (redirect) begin
            valid_nx = 1'b0;
            if (misaligned) begin
                fault_nx = 1'b1;
                state_nx = S_HALT;
            end else begin
                pc_nx    = redirect_target;
                instr_nx = NOP;
                unique case (state)
                    S_REQ:
                        state_nx = req_fire ? S_DROP : S_REQ;
                    // A response arriving now retires the stale
                    // request, so nothing is left to drop.
                    S_WAIT, S_DROP:
                        state_nx = imem_rsp_valid ? S_REQ : S_DROP;
                    default:
                        state_nx = S_REQ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= NOP;
            if_pc       <= RESET_PC;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            if_valid    <= valid_nx;
            if_instr    <= instr_nx;
            if_pc       <= ipc_nx;
            fetch_fault <= fault_nx;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: behavioural fetch model plus a small
// instruction memory with variable latency, directed and random phases.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model: next fetch address, one outstanding flag (possibly stale),
    // the output buffer and the fault flag.
    logic [31:0] m_pc;
    logic [31:0] m_bpc;
    bit          m_bv, m_out, m_stale, m_fault, m_started;

    // Memory
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat;

    bit          rnd;
    bit          d_ifr, d_rr, d_redir;
    logic [31:0] d_tgt;
    bit          last_rv;
    logic [31:0] last_addr;

    logic [31:0] hs_q[$];
    logic [31:0] cap_q[$];
    int          cap_cyc[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : SENT;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        if_ready        = 1'b0;
        d_redir = 1'b0;
        d_rr    = 1'b1;
        d_ifr   = 1'b1;
        d_tgt   = 32'h0;
        lat     = 1;
        m_pc = RPC; m_bpc = RPC;
        m_bv = 0; m_out = 0; m_stale = 0; m_fault = 0; m_started = 0;
        mem_busy = 0; mem_cnt = 0; mem_addr = 32'h0;
        hs_q.delete(); cap_q.delete(); cap_cyc.delete();
        cyc = 0;
        @(negedge clk);
        #1;
        chk("rst_instr", if_instr, 32'h0000_0013);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, RPC);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at the negedge, check, update model, wait.
    task automatic step();
        bit          rr, ifr, rd, rsp, rv_m, hs_m;
        logic [31:0] tgt;
        logic [31:0] rdata;
        if (rnd) begin
            ifr = $urandom_range(0, 3) != 0;
            rr  = $urandom_range(0, 2) != 0;
            rd  = m_started && ($urandom_range(0, 15) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8;
            if ($urandom_range(0, 39) == 0) tgt = tgt | 32'h2;
        end else begin
            ifr = d_ifr;
            rr  = d_rr;
            rd  = d_redir;
            tgt = d_tgt;
        end
        rsp   = 1'b0;
        rdata = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rsp = 1'b1;
                rdata = memf(mem_addr);
                mem_busy = 0;
            end
        end
        if_ready        = ifr;
        imem_req_ready  = rr;
        redirect_valid  = rd;
        redirect_target = tgt;
        imem_rsp_valid  = rsp;
        imem_rsp_data   = rdata;
        #1;

        rv_m = m_started && !m_fault && !m_out && (!m_bv || ifr);
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, rv_m});
        if (rv_m) chk("req_addr", imem_req_addr, m_pc);
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_bv});
        if (m_bv) begin
            chk("if_pc", if_pc, m_bpc);
            chk("if_instr", if_instr, memf(m_bpc));
        end
        chk("fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        last_rv   = imem_req_valid;
        last_addr = imem_req_addr;

        if (imem_req_valid && rr) begin
            chk("mem_overlap", {31'b0, mem_busy}, 32'd0);
            mem_busy = 1;
            mem_cnt  = rnd ? $urandom_range(1, 4) : lat;
            mem_addr = imem_req_addr;
            hs_q.push_back(imem_req_addr);
        end

        hs_m = rv_m && rr;
        if (!m_started) begin
            m_started = 1;
        end else if (!m_fault) begin
            if (rd) begin
                m_bv = 0;
                if (tgt[1:0] != 2'b00) begin
                    m_fault = 1;
                end else begin
                    if (m_out && rsp) begin
                        m_out = 0;
                        m_stale = 0;
                    end else if (m_out) begin
                        m_stale = 1;
                    end
                    if (hs_m) begin
                        m_out = 1;
                        m_stale = 1;
                    end
                    m_pc = tgt;
                end
            end else begin
                if (m_bv && ifr) m_bv = 0;
                if (m_out && rsp) begin
                    if (!m_stale) begin
                        m_bv  = 1;
                        m_bpc = m_pc;
                        cap_q.push_back(m_pc);
                        cap_cyc.push_back(cyc);
                        m_pc  = m_pc + 32'd4;
                    end
                    m_out = 0;
                    m_stale = 0;
                end
                if (hs_m) begin
                    m_out = 1;
                    m_stale = 0;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_hs(input int n);
        int k;
        k = 0;
        while (hs_q.size() < n && k < 40) begin
            step();
            k++;
        end
        chk("wait_hs_bound", {31'b0, hs_q.size() >= n}, 32'd1);
    endtask

    task automatic redirect_once(input logic [31:0] t);
        d_redir = 1'b1;
        d_tgt   = t;
        step();
        d_redir = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        rnd   = 1'b0;

        // Streaming with 1-cycle memory
        do_reset();
        run(7);
        chk("a_hs0", qat(hs_q, 0), 32'h100);
        chk("a_hs1", qat(hs_q, 1), 32'h104);
        chk("a_hs2", qat(hs_q, 2), 32'h108);
        chk("a_cap0", qat(cap_q, 0), 32'h100);
        chk("a_cap1", qat(cap_q, 1), 32'h104);
        chk("a_cap2", qat(cap_q, 2), 32'h108);
        if (cap_cyc.size() >= 3) begin
            chk("a_space1", cap_cyc[1] - cap_cyc[0], 32'd2);
            chk("a_space2", cap_cyc[2] - cap_cyc[1], 32'd2);
        end else begin
            chk("a_caps", cap_cyc.size(), 32'd3);
        end

        // Backpressure
        do_reset();
        d_ifr = 1'b0;
        wait_hs(1);
        run(6);
        chk("b_valid", {31'b0, if_valid}, 32'd1);
        chk("b_pc", if_pc, 32'h100);
        chk("b_instr", if_instr, memf(32'h100));
        chk("b_nreq", hs_q.size(), 32'd1);
        d_ifr = 1'b1;
        step();
        chk("b_rv_same", {31'b0, last_rv}, 32'd1);
        chk("b_addr", last_addr, 32'h104);
        chk("b_hs", qat(hs_q, 1), 32'h104);

        // Redirect in WAIT, latency 3
        do_reset();
        lat = 3;
        wait_hs(2);
        redirect_once(32'h200);
        run(12);
        chk("c_hs2", qat(hs_q, 2), 32'h200);
        chk("c_cap1", qat(cap_q, 1), 32'h200);
        chk("c_cap0", qat(cap_q, 0), 32'h100);

        // Redirect together with the response in WAIT
        do_reset();
        wait_hs(1);
        redirect_once(32'h300);
        run(8);
        chk("d_cap0", qat(cap_q, 0), 32'h300);
        chk("d_hs1", qat(hs_q, 1), 32'h300);

        // Redirect together with the handshake in REQ
        do_reset();
        lat = 2;
        step();
        redirect_once(32'h400);
        run(10);
        chk("e_hs0", qat(hs_q, 0), 32'h100);
        chk("e_hs1", qat(hs_q, 1), 32'h400);
        chk("e_cap0", qat(cap_q, 0), 32'h400);

        // Wrap, then misaligned target
        do_reset();
        step();
        d_rr = 1'b0;
        redirect_once(32'hFFFF_FFFC);
        d_rr = 1'b1;
        run(8);
        chk("f_hs0", qat(hs_q, 0), 32'hFFFF_FFFC);
        chk("f_hs1", qat(hs_q, 1), 32'h0000_0000);
        chk("f_cap1", qat(cap_q, 1), 32'h0000_0000);
        redirect_once(32'h0000_0202);
        n = hs_q.size();
        run(10);
        chk("f_fault", {31'b0, fetch_fault}, 32'd1);
        chk("f_noreq", hs_q.size(), n);
        redirect_once(32'h500);
        run(4);
        chk("f_sticky", {31'b0, fetch_fault}, 32'd1);

        // Async reset in the middle of WAIT
        do_reset();
        lat = 3;
        wait_hs(1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("g_rv", {31'b0, imem_req_valid}, 32'd0);
        chk("g_valid", {31'b0, if_valid}, 32'd0);
        chk("g_instr", if_instr, 32'h0000_0013);
        chk("g_pc", if_pc, RPC);
        chk("g_addr", imem_req_addr, RPC);
        do_reset();
        run(6);
        chk("g_restart", qat(hs_q, 0), 32'h100);

        // Random traffic
        rnd = 1'b1;
        for (int s = 0; s < 4; s++) begin
            do_reset();
            run(500);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
